// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding an elastic scan-code FIFO.
// Define PS2_RX_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES without a ps2_clk edge.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]      LAST_BIT  = 4'd10;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ps2_rx_fifo: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic clk_s0, clk_s1, clk_s2;
    logic data_s0, data_s1;
    logic fall;

    // NOTE: reset here is synchronous (sampled on the clock edge), so it sits
    // inside the posedge-only sensitivity list; all state uses non-blocking <=.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_s0  <= 1'b1;
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s0 <= 1'b1;
            data_s1 <= 1'b1;
        end else begin
            clk_s0  <= ps2_clk;
            clk_s1  <= clk_s0;
            clk_s2  <= clk_s1;
            data_s0 <= ps2_data;
            data_s1 <= data_s0;
        end
    end

    assign fall = clk_s2 & ~clk_s1;

    // ------------------------------------------------------------------
    // Frame assembly: shift holds start, data[7:0], parity (bit 0 = start)
    // ------------------------------------------------------------------
    logic [3:0] bit_cnt;
    logic [9:0] shift;
    logic       frame_done;
    logic       frame_ok;
    logic       timeout;

    assign frame_done = fall && (bit_cnt == LAST_BIT);
    assign frame_ok   = !shift[0] && data_s1 && (^shift[9:1]);

`ifdef PS2_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // A falling edge arriving on the expiry cycle still counts as a bit.
    assign timeout = !fall && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            idle_cnt <= '0;
        end else if (fall || bit_cnt == 4'd0 || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            bit_cnt <= 4'd0;
            shift   <= '0;
        end else if (timeout) begin
            bit_cnt <= 4'd0;
            shift   <= '0;
        end else if (fall) begin
            if (bit_cnt == LAST_BIT) begin
                bit_cnt <= 4'd0;
                shift   <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shift   <= {data_s1, shift[9:1]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= (frame_done && !frame_ok) || timeout;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   count;
    logic             full;
    logic             push_req;
    logic             push;
    logic             pop;
    logic [7:0]       rx_byte;

    assign rx_byte  = shift[8:1];
    assign full     = (count == FULL_CNT);
    assign ready    = (count != '0);
    assign pop      = !nextdata_n && ready;
    assign push_req = frame_done && frame_ok;
    // A full FIFO still accepts the byte when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign rd_next  = pop ? rd_ptr + 1'b1 : rd_ptr;

    // NOTE: the storage array is deliberately not reset; ready gates its
    // contents, and leaving it reset-free lets it map onto plain RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Registered head: bypass the incoming byte when it lands at the new head.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            data <= 8'h00;
        end else if (push || pop) begin
            if (push && wr_ptr == rd_next) begin
                data <= rx_byte;
            end else begin
                data <= mem[rd_next];
            end
        end
    end

endmodule
